imem_loader: RTL and testbench
==============================

# imem_loader

Sequential program loader that writes the instruction memory from a byte stream. A host link (UART receiver or testbench) supplies bytes on a valid/ready interface. The block frames them as a length header, little-endian 32-bit instruction words and an XOR checksum. It drives a one-word-per-write port on the instruction RAM and holds the CPU in reset while a load is in progress.

## Interface
- DEPTH, 512, instruction memory size in 32-bit words
- AW, 9, word-address width, equal to log2(DEPTH)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction RAM write strobe
- mem_addr  out  AW  word address; the byte address is mem_addr<<2
- mem_wd  out  32  instruction word
- cpu_hold  out  1  holds the CPU pipeline in reset
- busy  out  1  a load is in progress
- done  out  1  last load completed with a good checksum
- error  out  1  last load failed
- words_loaded  out  AW+1  count of words written in the current or last load

## Operation
- A byte is accepted only on a clk edge where in_valid and in_ready are both 1. The block ignores in_data at all other times.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- in_ready = 1 only in LEN_LO, LEN_HI, DATA and CSUM. This is a pure state decode.
- busy = 1 in LEN_LO, LEN_HI, DATA and CSUM.
- IDLE, DONE or ERR with start = 1:
  - go to LEN_LO;
  - clear done, error, words_loaded, the checksum accumulator and the byte lane;
  - set cpu_hold = 1.
- start is ignored while busy.
- LEN_LO accepts length[7:0]. LEN_HI accepts length[15:8].
- After LEN_HI, the length is checked:
  - length = 0 or length > DEPTH: go to ERR;
  - otherwise: go to DATA.
- DATA assembles bytes little-endian. The first byte is wd[7:0] and the fourth byte is wd[31:24].
  - A 2-bit lane counter wraps from 3 to 0.
  - When the 4th byte is accepted, the block issues a write to word address words_loaded[AW-1:0], then increments words_loaded.
  - When words_loaded reaches length, go to CSUM.
- Checksum: the accumulator is the XOR of every accepted byte, including both length bytes and all data bytes.
- CSUM accepts one byte and compares it to the accumulator:
  - equal: go to DONE, done = 1, cpu_hold = 0;
  - not equal: go to ERR, error = 1, cpu_hold stays 1.
- DONE and ERR persist until the next start or reset.
- Words already written before an error are not rolled back. The CPU stays held, so they never execute.
- Reset, asynchronous, may occur mid-load:
  - state = IDLE;
  - in_ready, mem_we, cpu_hold, busy, done and error = 0;
  - mem_addr, mem_wd and words_loaded = 0;
  - the lane counter and accumulator are cleared;
  - the CPU runs whatever the RAM already holds.
- A partial word left by a reset or by an error is discarded. No write is issued for it.

## Timing
- mem_we, mem_addr and mem_wd are registered.
  - mem_we is high for exactly 1 cycle: the cycle after the edge that accepted the 4th byte of a word.
  - mem_addr and mem_wd are stable during that cycle.
- The RAM samples the write on the next rising edge.
- Back-to-back words at 1 byte per cycle give one mem_we every 4 cycles. The write port never sees two consecutive mem_we cycles.
- State transitions:
  - start → LEN_LO takes effect on the next edge; in_ready rises 1 cycle after start;
  - the checksum byte accepted at edge N gives done or error = 1 and busy = 0 after edge N;
  - cpu_hold falls on that same edge for a good load.
- If the last data word's mem_we is still pending when the checksum byte arrives, that write completes before done is visible. The RAM contents are therefore complete whenever done = 1.
- words_loaded updates on the same edge that registers mem_we, so it leads the RAM write by 1 cycle.
- in_valid may stay high across state changes. The first byte is never accepted earlier than the cycle after start.

## Test plan
- Good load: start, then bytes 02 00 0A 00 A0 E3 FE FF FF EA 5F at 1 byte/cycle.
  - Required: writes (0, E3A0000A) and (1, EAFFFFFE), each mem_we 1 cycle wide;
  - done = 1, error = 0, words_loaded = 2, cpu_hold = 0.
- Bad checksum: same stream but the last byte is 5E.
  - Required: both writes still occur; error = 1, done = 0, cpu_hold stays 1.
- Length errors:
  - bytes 00 00 give ERR immediately after LEN_HI, with no writes;
  - bytes 01 02 (length 513) give ERR with no writes;
  - length 512 (bytes 00 02) is accepted.
- Throttled stream: same good load with in_valid toggling randomly and idle gaps of up to 5 cycles.
  - Required: identical writes and checksum result;
  - bytes presented while in_ready = 0 are not consumed.
- Reset mid-word: assert reset after the 2nd data byte of word 1.
  - Required: all outputs go to 0 asynchronously, with no write for the partial word;
  - a fresh good load afterwards completes correctly.
- start ignored while busy: pulse start during DATA.
  - Required: the load continues unaffected and the byte lane is not cleared.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: frames a byte stream (length, LE words, XOR checksum)
// into one-word RAM writes and holds the CPU in reset while a load is in flight.
`timescale 1ns/1ps
module imem_loader #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);
  localparam logic [AW:0] ONE     = 1;

  state_t        state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    acc_q, acc_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   wd_q, wd_d;
  logic [AW:0]   words_q, words_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wd_q, mem_wd_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          accept;
  logic [15:0]   len_full;
  logic [AW:0]   words_inc;

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign len_full  = {in_data, len_lo_q};
  assign words_inc = words_q + ONE;

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    acc_d      = acc_q;
    lane_d     = lane_q;
    wd_d       = wd_q;
    words_d    = words_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          done_d     = 1'b0;
          error_d    = 1'b0;
          words_d    = '0;
          acc_d      = '0;
          lane_d     = '0;
          cpu_hold_d = 1'b1;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          acc_d    = acc_q ^ in_data;
          state_d  = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          acc_d = acc_q ^ in_data;
          if (len_full == '0 || len_full > DEPTH16) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            len_d   = len_full[AW:0];
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          acc_d  = acc_q ^ in_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: wd_d[7:0]   = in_data;
            2'd1: wd_d[15:8]  = in_data;
            2'd2: wd_d[23:16] = in_data;
            default: begin
              // Fourth byte completes the word straight into the write register.
              mem_we_d   = 1'b1;
              mem_addr_d = words_q[AW-1:0];
              mem_wd_d   = {in_data, wd_q};
              words_d    = words_inc;
              if (words_inc == len_q) state_d = S_CSUM;
            end
          endcase
        end
      end

      S_CSUM: begin
        if (accept) begin
          if (in_data == acc_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      lane_q     <= '0;
      wd_q       <= '0;
      words_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      lane_q     <= lane_d;
      wd_q       <= wd_d;
      words_q    <= words_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wd       = mem_wd_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load streams with expected end status, plus
// hand-written reset-mid-word, start-while-busy and full-depth sequences.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wd;
  } wr_t;

  typedef struct {
    string        name;
    logic [127:0] bytes;
    int unsigned  n;
    bit           thr;
    logic         exp_done;
    logic         exp_err;
    logic         exp_hold;
    logic [AW:0]  exp_words;
  } vec_t;

  wr_t        exp_q[$];
  logic [7:0] stream[$];
  vec_t       vecs[6];
  int         checks = 0;
  int         errors = 0;
  logic       prev_we = 1'b0;
  wr_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write scoreboard: every mem_we must match the next expected write
  always @(negedge clk) begin
    if (mem_we) begin
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL back_to_back_we: got 1 expected 0 at addr %h", mem_addr);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wd);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_wd !== mon_e.wd) begin
          errors++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   mem_addr, mem_wd, mon_e.addr, mon_e.wd);
        end
      end
    end
    prev_we = mem_we;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic load_vec(input vec_t v);
    stream.delete();
    for (int unsigned k = 0; k < v.n; k++)
      stream.push_back(v.bytes[8*(v.n-1-k) +: 8]);
  endtask

  task automatic model_push();
    int unsigned len;
    wr_t         w;
    len = {stream[1], stream[0]};
    if (len == 0 || len > DEPTH) return;
    for (int unsigned i = 0; i < len; i++) begin
      int unsigned idx;
      idx = 2 + 4*i;
      if (idx + 3 < stream.size()) begin
        w.addr = i[AW-1:0];
        w.wd   = {stream[idx+3], stream[idx+2], stream[idx+1], stream[idx]};
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr, input bit pulse);
    bit acc;
    if (thr) begin
      int unsigned g;
      in_valid = 1'b0;
      g = $urandom_range(0, 5);
      for (int unsigned i = 0; i < g; i++) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = pulse;
    acc      = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("byte_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic do_start();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("ready_in_start_cycle", in_ready, 0);
    @(posedge clk);
    #1 start = 1'b0;
    chk("ready_after_start", in_ready, 1);
    chk("busy_after_start", busy, 1);
    chk("hold_after_start", cpu_hold, 1);
    chk("done_cleared", done, 0);
    chk("error_cleared", error, 0);
    chk("words_cleared", words_loaded, 0);
  endtask

  task automatic run_load(input bit thr, input int start_at, input int unsigned nbytes);
    do_start();
    for (int k = 0; k < int'(nbytes); k++)
      send_byte(stream[k], thr, k == start_at);
    in_valid = 1'b0;
  endtask

  task automatic check_end(input string name, input logic d, input logic e,
                           input logic h, input logic [AW:0] w);
    @(negedge clk);
    chk({name, "_done"}, done, d);
    chk({name, "_error"}, error, e);
    chk({name, "_hold"}, cpu_hold, h);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_words"}, words_loaded, w);
    chk({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic set_vec(input int i, input string nm, input logic [127:0] b,
                         input int unsigned n, input bit thr, input logic d,
                         input logic e, input logic h, input logic [AW:0] w);
    vecs[i].name = nm;  vecs[i].bytes = b;    vecs[i].n = n;
    vecs[i].thr  = thr; vecs[i].exp_done = d; vecs[i].exp_err = e;
    vecs[i].exp_hold = h; vecs[i].exp_words = w;
  endtask

  initial begin
    logic [127:0] good;
    logic [7:0]   cs;
    logic [31:0]  wd;

    good = {8'h02, 8'h00, 8'h0A, 8'h00, 8'hA0, 8'hE3, 8'hFE, 8'hFF, 8'hFF, 8'hEA, 8'h5F};
    set_vec(0, "good",      good, 11, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2);
    set_vec(1, "bad_csum",  {8'h02, 8'h00, 8'h0A, 8'h00, 8'hA0, 8'hE3, 8'hFE, 8'hFF, 8'hFF, 8'hEA, 8'h5E},
            11, 1'b0, 1'b0, 1'b1, 1'b1, 10'd2);
    set_vec(2, "len_zero",  {8'h00, 8'h00}, 2, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
    set_vec(3, "len_513",   {8'h01, 8'h02}, 2, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
    set_vec(4, "one_word",  {8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45},
            7, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1);
    set_vec(5, "throttled", good, 11, 1'b1, 1'b1, 1'b0, 1'b0, 10'd2);

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_words", words_loaded, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load_vec(vecs[i]);
      model_push();
      run_load(vecs[i].thr, -1, vecs[i].n);
      check_end(vecs[i].name, vecs[i].exp_done, vecs[i].exp_err,
                vecs[i].exp_hold, vecs[i].exp_words);
    end

    // Reset after the second byte of word 1: only word 0 may be written
    load_vec(vecs[0]);
    wd = 32'hE3A0000A;
    mon_e.addr = '0;
    mon_e.wd   = wd;
    exp_q.push_back(mon_e);
    run_load(1'b0, -1, 8);
    chk("pre_reset_words", words_loaded, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wd", mem_wd, 0);
    chk("mid_rst_words", words_loaded, 0);
    chk("mid_rst_pending", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    load_vec(vecs[0]);
    model_push();
    run_load(1'b0, -1, 11);
    check_end("after_reset", 1'b1, 1'b0, 1'b0, 10'd2);

    // start pulsed with the second byte of word 1 must be ignored
    load_vec(vecs[0]);
    model_push();
    run_load(1'b0, 7, 11);
    check_end("start_busy", 1'b1, 1'b0, 1'b0, 10'd2);

    // Full-depth load (length 512)
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h02);
    cs = 8'h02;
    for (int unsigned w = 0; w < DEPTH; w++) begin
      wd = (w * 32'h9E3779B1) ^ 32'h13579BDF;
      for (int unsigned k = 0; k < 4; k++) begin
        stream.push_back(wd[8*k +: 8]);
        cs = cs ^ wd[8*k +: 8];
      end
    end
    stream.push_back(cs);
    model_push();
    chk("len512_model_writes", exp_q.size(), DEPTH);
    run_load(1'b0, -1, stream.size());
    check_end("len_512", 1'b1, 1'b0, 1'b0, 10'd512);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
